// File: rtl/gmii_tx_speed_adapter_if.sv
// MAC-side byte stream and PHY-side symbol stream of the GMII/MII TX speed adapter.
// The master modport is the MAC (and PHY observer); the slave modport is the adapter.
interface gmii_tx_speed_adapter_if;
  logic [7:0] mac_txd;
  logic       mac_tx_en;
  logic       mac_tx_er;
  logic       mac_tx_ready;
  logic [7:0] phy_txd;
  logic       phy_tx_en;
  logic       phy_tx_er;
  logic       phy_tx_ce;

  modport master (
    output mac_txd, mac_tx_en, mac_tx_er,
    input  mac_tx_ready,
    input  phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce
  );

  modport slave (
    input  mac_txd, mac_tx_en, mac_tx_er,
    output mac_tx_ready,
    output phy_txd, phy_tx_en, phy_tx_er, phy_tx_ce
  );
endinterface

// File: rtl/gmii_tx_speed_adapter.sv
// Single-clock GMII/MII TX adapter: bytes per cycle at 1000, prescaled nibbles (low first) at 100/10.
// Define GMII_TX_IFG_EN to enforce an IFG_BYTES inter-frame gap after every frame.
module gmii_tx_speed_adapter #(
  parameter int unsigned DIV_100   = 5,
  parameter int unsigned DIV_10    = 50,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    speed,
  gmii_tx_speed_adapter_if.slave        bus,
  output logic [1:0]                    active_speed,
  output logic                          busy
);

  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [1:0] SPD_100  = 2'b01;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GMII   = 3'd1;
  localparam logic [2:0] ST_MII_HI = 3'd2;
  localparam logic [2:0] ST_MII_LO = 3'd3;
`ifdef GMII_TX_IFG_EN
  localparam logic [2:0] ST_IFG    = 3'd4;
  localparam logic [2:0] ST_END    = ST_IFG;
  localparam int unsigned IFG_W    = $clog2(2 * IFG_BYTES + 1);
`else
  localparam logic [2:0] ST_END    = ST_IDLE;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       active_speed_q, active_speed_d;
  logic             live_q, live_d;
  logic [7:0]       txd_q, txd_d;
  logic             en_q, en_d;
  logic             er_q, er_d;
  logic             ce_q, ce_d;
  logic [3:0]       hi_q, hi_d;
  logic             hi_er_q, hi_er_d;
  logic             busy_q, busy_d;
`ifdef GMII_TX_IFG_EN
  logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
  logic [IFG_W-1:0] ifg_last_c;
`endif

  logic [1:0]       speed_map_c;
  logic             spd_chg_c;
  logic             is_gmii_c;
  logic [CNT_W-1:0] div_last_c;
  logic             sym_ce_c;
  logic             ready_c;

  // Prescaler and speed latch; a speed change restarts the prescaler and swallows that strobe.
  always_comb begin
    speed_map_c    = (speed == 2'b11) ? SPD_1000 : speed;
    is_gmii_c      = (active_speed_q == SPD_1000);
    div_last_c     = (active_speed_q == SPD_100) ? CNT_W'(DIV_100 - 1) : CNT_W'(DIV_10 - 1);
    spd_chg_c      = (state_q == ST_IDLE) && (speed_map_c != active_speed_q);
    active_speed_d = spd_chg_c ? speed_map_c : active_speed_q;
    live_d         = 1'b1;
    cnt_d          = cnt_q + CNT_W'(1);
    if (spd_chg_c || is_gmii_c || (cnt_q == div_last_c)) begin
      cnt_d = '0;
    end
    sym_ce_c = live_q && !spd_chg_c && (is_gmii_c || (cnt_q == div_last_c));
`ifdef GMII_TX_IFG_EN
    ifg_last_c = is_gmii_c ? IFG_W'(IFG_BYTES - 1) : IFG_W'(2 * IFG_BYTES - 1);
`endif
  end

  // Next-state and output logic; every consume or high-nibble strobe updates the phy_* outputs.
  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    en_d    = en_q;
    er_d    = er_q;
    ce_d    = 1'b0;
    hi_d    = hi_q;
    hi_er_d = hi_er_q;
    ready_c = 1'b0;
`ifdef GMII_TX_IFG_EN
    ifg_cnt_d = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_c = sym_ce_c;
        if (sym_ce_c) begin
          ce_d = 1'b1;
          er_d = bus.mac_tx_er;
          if (bus.mac_tx_en) begin
            en_d = 1'b1;
            if (is_gmii_c) begin
              txd_d   = bus.mac_txd;
              state_d = ST_GMII;
            end else begin
              txd_d   = {4'h0, bus.mac_txd[3:0]};
              hi_d    = bus.mac_txd[7:4];
              hi_er_d = bus.mac_tx_er;
              state_d = ST_MII_HI;
            end
          end else begin
            txd_d = '0;
            en_d  = 1'b0;
          end
        end
      end
      ST_GMII: begin
        ready_c = sym_ce_c;
        if (sym_ce_c) begin
          ce_d  = 1'b1;
          txd_d = bus.mac_txd;
          en_d  = bus.mac_tx_en;
          er_d  = bus.mac_tx_er;
          if (!bus.mac_tx_en) begin
            state_d = ST_END;
          end
        end
      end
      ST_MII_HI: begin
        if (sym_ce_c) begin
          ce_d    = 1'b1;
          txd_d   = {4'h0, hi_q};
          en_d    = 1'b1;
          er_d    = hi_er_q;
          state_d = ST_MII_LO;
        end
      end
      ST_MII_LO: begin
        ready_c = sym_ce_c;
        if (sym_ce_c) begin
          ce_d    = 1'b1;
          txd_d   = {4'h0, bus.mac_txd[3:0]};
          en_d    = bus.mac_tx_en;
          er_d    = bus.mac_tx_er;
          hi_d    = bus.mac_txd[7:4];
          hi_er_d = bus.mac_tx_er;
          state_d = bus.mac_tx_en ? ST_MII_HI : ST_END;
        end
      end
`ifdef GMII_TX_IFG_EN
      ST_IFG: begin
        txd_d     = '0;
        en_d      = 1'b0;
        er_d      = 1'b0;
        ifg_cnt_d = ifg_cnt_q;
        if (sym_ce_c) begin
          if (ifg_cnt_q == ifg_last_c) begin
            state_d = ST_IDLE;
          end else begin
            ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      active_speed_q <= SPD_1000;
      live_q         <= 1'b0;
      txd_q          <= '0;
      en_q           <= 1'b0;
      er_q           <= 1'b0;
      ce_q           <= 1'b0;
      hi_q           <= '0;
      hi_er_q        <= 1'b0;
      busy_q         <= 1'b0;
`ifdef GMII_TX_IFG_EN
      ifg_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      active_speed_q <= active_speed_d;
      live_q         <= live_d;
      txd_q          <= txd_d;
      en_q           <= en_d;
      er_q           <= er_d;
      ce_q           <= ce_d;
      hi_q           <= hi_d;
      hi_er_q        <= hi_er_d;
      busy_q         <= busy_d;
`ifdef GMII_TX_IFG_EN
      ifg_cnt_q      <= ifg_cnt_d;
`endif
    end
  end

  assign bus.mac_tx_ready = ready_c;
  assign bus.phy_txd      = txd_q;
  assign bus.phy_tx_en    = en_q;
  assign bus.phy_tx_er    = er_q;
  assign bus.phy_tx_ce    = ce_q;
  assign active_speed     = active_speed_q;
  assign busy             = busy_q;

endmodule

// File: doc/gmii_tx_speed_adapter.md
# gmii_tx_speed_adapter

Single-clock, multi-speed GMII/MII transmit adapter for the MAC-to-PHY path. It takes a byte-wide GMII-style stream from the MAC with a ready handshake and drives a registered PHY-side symbol stream with a symbol strobe. In 1000 mode it emits one byte per cycle; in 100 and 10 modes it emits one nibble per prescaled strobe. It sits between the MAC TX and the SDR output stage, replacing the clock-mux approach with a clock-enable scheme on a single 125 MHz clock.

## Interface
Parameters:
- DIV_100, 5: clk cycles per symbol in 100 mode (125 MHz / 25 MHz).
- DIV_10, 50: clk cycles per symbol in 10 mode.
- CNT_W, 6: prescaler width; must satisfy 2^CNT_W > DIV_10.
- IFG_BYTES, 12: minimum inter-frame gap in byte times (used only with the IFG macro).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock, 125 MHz.
- rst_n  in  1  synchronous reset, active low.
- speed  in  2  requested speed: 2'b10 = 1000, 2'b01 = 100, 2'b00 = 10, 2'b11 = treated as 1000.
- mac_txd  in  8  MAC byte.
- mac_tx_en  in  1  MAC frame valid.
- mac_tx_er  in  1  MAC error.
- mac_tx_ready  out  1  byte consumed this cycle.
- phy_txd  out  8  PHY symbol; bits [7:4] are 0 in MII modes.
- phy_tx_en  out  1  PHY TX enable.
- phy_tx_er  out  1  PHY TX error.
- phy_tx_ce  out  1  one-cycle pulse when a new symbol appears on the phy_* outputs.
- active_speed  out  2  speed currently in effect.
- busy  out  1  high in any state other than IDLE.

## Operation
Prescaler:
- Internal sym_ce. In 1000 mode it is constantly 1.
- In 100 and 10 modes, counter cnt runs 0..DIV-1. sym_ce=1 when cnt==DIV-1, then cnt wraps to 0.

Speed latch:
- active_speed takes speed (11 mapped to 10) only while in IDLE, on a cycle where the value differs. That change forces cnt=0 and suppresses sym_ce on that cycle.
- A speed change during a frame or the IFG is deferred until IDLE.

Handshake:
- mac_tx_ready is a function of state and sym_ce only. It never depends on mac_tx_en.
- A byte is consumed on every cycle with mac_tx_ready=1. The MAC must present valid data, or mac_tx_en=0 for idle.

States:
- IDLE: ready=sym_ce.
  - Consume with en=1: in 1000 go to GMII; else go to MII_HI.
  - Consume with en=0: outputs take idle, er passed through.
- GMII: ready=sym_ce. Each consume registers {txd, en, er}.
  - Consume with en=0 ends the frame: go to IFG (macro on) or IDLE.
- MII_HI (high nibble pending): ready=0.
  - On sym_ce, drive the stored high nibble with the stored en/er.
  - Then go to MII_LO.
- MII_LO: ready=sym_ce. On consume, drive {4'h0, mac_txd[3:0]} and store mac_txd[7:4].
  - en=1: go to MII_HI.
  - en=0: frame end, go to IFG or IDLE.
- IFG (macro only): ready=0, outputs idle (en=0, er=0, txd=0).
  - ifg_cnt counts symbol strobes up to IFG_BYTES in 1000 mode, or 2*IFG_BYTES in MII modes.
  - Then go to IDLE.

Common rules:
- The low nibble is always sent first in MII modes.
- phy_tx_ce is the registered sym_ce, gated to cycles where outputs were updated.

## Timing
- Reset (rst_n=0 sampled at posedge) puts everything in its initial state:
  - phy_txd=0, phy_tx_en=0, phy_tx_er=0, phy_tx_ce=0, mac_tx_ready=0.
  - busy=0, active_speed=2'b10, cnt=0, state IDLE.
- mac_tx_ready rises on the first cycle after reset release.
- Latency is 1 cycle from the consume edge to the phy_* update. phy_tx_ce is high in that same cycle.
- 1000 mode: sustained 1 byte/cycle, no bubbles.
- 100 mode: one nibble per 5 cycles, one byte per 10 cycles.
- 10 mode: one nibble per 50 cycles.
- Outputs hold their value between strobes.
- Reset asserted mid-frame aborts immediately. phy_tx_en=0 on the next cycle, and no trailing nibble is sent.

## Configuration
- Macro GMII_TX_IFG_EN.
- When defined: the IFG state is compiled in. After every frame end, mac_tx_ready stays low for IFG_BYTES byte times and the outputs stay idle.
- When undefined: the IFG state and ifg_cnt are absent. Frame end returns directly to IDLE, and the MAC is responsible for the gap.

## Test plan
- Reset release in 1000 mode, bytes 0x55×7, 0xD5, 0x01..0x40, then en=0 → phy_txd follows 1 cycle later each cycle, and phy_tx_en falls 1 cycle after en=0.
- 100 mode, byte 0xA5 → phy_txd=0x05 then 0x0A, 5 cycles apart, each with phy_tx_ce=1. mac_tx_ready pulses every 10 cycles.
- 10 mode, 4-byte frame → 8 nibbles at 50-cycle spacing. busy=1 throughout, then busy=0.
- speed changed 10→1000 mid-frame → active_speed stays 00 until frame end (plus the IFG), then becomes 10. The next frame runs at 1 byte/cycle.
- GMII_TX_IFG_EN defined, 1000 mode, back-to-back frames → 12 cycles with mac_tx_ready=0 and phy_tx_en=0 between frames. In 100 mode, 120 cycles.
- rst_n=0 mid-frame in MII_HI → the next cycle phy_tx_en=0, phy_txd=0, active_speed=10, and no high nibble is emitted.
